fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the pipelined RV32I core; owns the PC, issues requests to instruction memory over a valid/ready request and valid response interface, and drives the IF/ID pipeline register consumed by decode. Accepts stall from the hazard unit and flush/redirect from the branch-resolution logic in EX. Supports variable instruction-memory latency, one outstanding request, and a one-entry skid buffer so a returning instruction is never lost under stall.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, value driven on if_id_instruction for bubbles (addi x0,x0,0)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold IF/ID (load-use hazard)
- flush  in  1  redirect fetch to pc_target, kill IF/ID
- pc_target  in  32  redirect address, sampled when flush=1
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction returned
- imem_resp_data  in  32  returned instruction
- pc  out  32  address of next request
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_instruction  out  32  instruction to decode

## Operation
- Registers: pc, req_pc (PC of outstanding request), state, drop flag, skid_valid/skid_pc/skid_instr, IF/ID (valid, pc, instruction).
- FSM states: FETCH, WAIT, HOLD.
- FETCH: imem_req_valid=1, imem_req_addr=pc. On valid&&ready: req_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), ->WAIT.
- WAIT: imem_req_valid=0. On imem_resp_valid: if drop, discard data, drop<=0, ->FETCH; else if !stall, load IF/ID {1, req_pc, data}, ->FETCH; else load skid, ->HOLD.
- HOLD: imem_req_valid=0. When stall=0: IF/ID<=skid, skid_valid<=0, ->FETCH.
- IF/ID update when no new instruction enters: stall=1 holds contents; stall=0 loads bubble {0, 0, NOP_INSTR}.
- flush has priority over stall and over any response: IF/ID<=bubble, skid cleared, pc<=pc_target, and
  - FETCH with request handshake same cycle: ->WAIT, drop<=1 (response of cancelled request discarded)
  - FETCH without handshake: stay FETCH
  - WAIT with imem_resp_valid same cycle: response discarded, ->FETCH, drop<=0
  - WAIT without response: stay WAIT, drop<=1
  - HOLD: ->FETCH
- Memory contract: imem_resp_valid only asserted while in WAIT, at least one cycle after acceptance; response in FETCH/HOLD is a protocol error, ignored.
- pc_target low two bits are not checked; used as given.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=FETCH, drop=0, skid_valid=0, if_id_valid=0, if_id_pc=0, if_id_instruction=NOP_INSTR; imem_req_valid=0 while reset high, imem_req_addr=RESET_PC.
- First cycle after reset release: imem_req_valid=1, addr=RESET_PC.
- Reset mid-transaction: outstanding request abandoned; no drop tracking survives reset (memory is reset concurrently).
- Ready-always, 1-cycle memory: request cycle N, response N+1, IF/ID valid from N+2; steady throughput 1 instruction per 2 cycles.
- Request held stable (valid, addr) until ready; addr changes only on flush.
- Stall release from HOLD: instruction visible in IF/ID the cycle after stall falls; next request issued that same following cycle.
- Flush latency: request to pc_target issued the cycle after flush (FETCH) or after the dropped response returns (WAIT).

## Test plan
- Reset release, ready=1, 1-cycle memory returning mem[addr>>2]: IF/ID shows PCs 0x0,0x4,0x8 with valid pulses every 2 cycles, bubbles (NOP 0x00000013, valid=0) between.
- imem_req_ready low for 3 cycles at pc=0x8: req_valid held, addr stays 0x8, pc stays 0x8 until handshake.
- stall=1 while response for 0xC returns: IF/ID keeps 0x8 instruction, skid holds 0xC; stall falls -> IF/ID=0xC next cycle, no instruction lost or duplicated.
- flush with pc_target=0x40 while in WAIT for 0x10, response arrives 2 cycles later: that response discarded, next request addr=0x40, IF/ID never shows 0x10.
- flush and stall together while IF/ID holds 0x14: IF/ID becomes bubble, skid cleared, fetch resumes at target.
- pc=0xFFFF_FFFC handshake -> pc wraps to 0x0000_0000; assert reset mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Owns the PC, issues one
//               outstanding request to instruction memory, absorbs a
//               returning instruction into a one-entry skid buffer under
//               stall, and drives the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_drop;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_pc_nxt;
    logic        w_drop_nxt;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic        w_if_id_valid_nxt;
    logic [31:0] w_if_id_pc_nxt;
    logic [31:0] w_if_id_instr_nxt;
    logic        w_req_fire;

    // Request is held stable in FETCH until accepted; silenced while in reset
    assign imem_req_valid    = (r_state == c_st_fetch) && !reset;
    assign imem_req_addr     = r_pc;
    assign pc                = r_pc;
    assign if_id_valid       = r_if_id_valid;
    assign if_id_pc          = r_if_id_pc;
    assign if_id_instruction = r_if_id_instr;
    assign w_req_fire        = (r_state == c_st_fetch) && imem_req_ready;

    // State register: all fetch-stage state, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_fetch;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_drop        <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_pc     <= 32'h0;
            r_skid_instr  <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= 32'h0;
            r_if_id_instr <= NOP_INSTR;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
        end
    end

    // Next-state logic: normal fetch flow first, then flush overrides it
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_pc_nxt     = r_req_pc;
        w_drop_nxt       = r_drop;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        // With nothing new arriving, IF/ID either holds (stall) or drains to a bubble
        if (stall) begin
            w_if_id_valid_nxt = r_if_id_valid;
            w_if_id_pc_nxt    = r_if_id_pc;
            w_if_id_instr_nxt = r_if_id_instr;
        end else begin
            w_if_id_valid_nxt = 1'b0;
            w_if_id_pc_nxt    = 32'h0;
            w_if_id_instr_nxt = NOP_INSTR;
        end

        case (r_state)
            c_st_fetch: begin
                if (w_req_fire) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = c_st_wait;
                end
            end
            c_st_wait: begin
                if (imem_resp_valid) begin
                    w_state_nxt = c_st_fetch;
                    if (r_drop) begin
                        // Response belongs to a request cancelled by an earlier flush
                        w_drop_nxt = 1'b0;
                    end else if (!stall) begin
                        w_if_id_valid_nxt = 1'b1;
                        w_if_id_pc_nxt    = r_req_pc;
                        w_if_id_instr_nxt = imem_resp_data;
                    end else begin
                        // Decode is stalled: park the instruction so it is not lost
                        w_skid_valid_nxt = 1'b1;
                        w_skid_pc_nxt    = r_req_pc;
                        w_skid_instr_nxt = imem_resp_data;
                        w_state_nxt      = c_st_hold;
                    end
                end
            end
            c_st_hold: begin
                if (!stall) begin
                    w_if_id_valid_nxt = r_skid_valid;
                    w_if_id_pc_nxt    = r_skid_pc;
                    w_if_id_instr_nxt = r_skid_instr;
                    w_skid_valid_nxt  = 1'b0;
                    w_state_nxt       = c_st_fetch;
                end
            end
            default: w_state_nxt = c_st_fetch;
        endcase

        if (flush) begin
            w_if_id_valid_nxt = 1'b0;
            w_if_id_pc_nxt    = 32'h0;
            w_if_id_instr_nxt = NOP_INSTR;
            w_skid_valid_nxt  = 1'b0;
            w_pc_nxt          = pc_target;
            case (r_state)
                c_st_fetch: begin
                    // A request accepted this cycle is now stale; its response must be dropped
                    if (w_req_fire) begin
                        w_state_nxt = c_st_wait;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_st_fetch;
                    end
                end
                c_st_wait: begin
                    if (imem_resp_valid) begin
                        w_state_nxt = c_st_fetch;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = c_st_wait;
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = c_st_fetch;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural instruction
//               memory answers requests; expected IF/ID contents are queued
//               by each scenario and checked as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] pc_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .pc_target        (pc_target),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .pc               (pc),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: each word is distinct from NOP and encodes its address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // One clock: memory model answers accepted requests, scoreboard checks IF/ID
    task automatic tick();
        logic        hs;
        logic        st;
        logic        fl;
        logic [31:0] a;
        logic [31:0] e;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        st = stall;
        fl = flush;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (hs) begin
            mem_cnt  = mem_lat;
            mem_addr = a;
        end
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mem_addr);
            end
        end
        if (!reset) begin
            if (if_id_valid && !(st && !fl)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, required no new instruction", if_id_pc, if_id_instruction);
                end else begin
                    e = exp_q.pop_front();
                    if (if_id_pc !== e || if_id_instruction !== instr_of(e)) begin
                        n_err++;
                        $display("FAIL sb_ifid: got pc=%h instr=%h, required pc=%h instr=%h", if_id_pc, if_id_instruction, e, instr_of(e));
                    end
                end
            end else if (!if_id_valid) begin
                n_cmp++;
                if (if_id_pc !== 32'h0 || if_id_instruction !== NOP) begin
                    n_err++;
                    $display("FAIL sb_bubble: got pc=%h instr=%h, required pc=0 instr=%h", if_id_pc, if_id_instruction, NOP);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_req: got valid=%b addr=%h pc=%h, required 0/0/0", imem_req_valid, imem_req_addr, pc);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instruction !== NOP) begin
            n_err++;
            $display("FAIL reset_ifid: got %b/%h/%h, required 0/0/%h", if_id_valid, if_id_pc, if_id_instruction, NOP);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: got valid=%b addr=%h, required 1/0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        repeat (4) tick();
        n_cmp++;
        if (exp_q.size() != 0 || pc !== 32'h8 || imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_end: got left=%0d pc=%h valid=%b, required 0/8/1", exp_q.size(), pc, imem_req_valid);
        end
    endtask

    task automatic test_ready_low();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || pc !== 32'h8) begin
                n_err++;
                $display("FAIL ready_low_hold: got valid=%b addr=%h pc=%h, required 1/8/8", imem_req_valid, imem_req_addr, pc);
            end
        end
        imem_req_ready = 1'b1;
        exp_q.push_back(32'h8);
        repeat (2) tick();
        n_cmp++;
        if (pc !== 32'hC || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ready_low_end: got pc=%h left=%0d, required C/0", pc, exp_q.size());
        end
    endtask

    task automatic test_stall_skid();
        stall = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instruction !== instr_of(32'h8) || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: got %b/%h/%h req=%b, required 1/8/%h req=0", if_id_valid, if_id_pc, if_id_instruction, imem_req_valid, instr_of(32'h8));
        end
        exp_q.push_back(32'hC);
        stall = 1'b0;
        tick();
        n_cmp++;
        if (exp_q.size() != 0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_err++;
            $display("FAIL stall_release: got left=%0d valid=%b addr=%h, required 0/1/10", exp_q.size(), imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_flush_wait();
        mem_lat = 3;
        tick();
        flush = 1'b1;
        pc_target = 32'h40;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (pc !== 32'h40 || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait_pc: got pc=%h valid=%b, required 40/0", pc, imem_req_valid);
        end
        repeat (2) tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || if_id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait_drop: got valid=%b addr=%h ifid_v=%b, required 1/40/0", imem_req_valid, imem_req_addr, if_id_valid);
        end
        mem_lat = 1;
        exp_q.push_back(32'h40);
        repeat (2) tick();
    endtask

    task automatic test_flush_stall();
        imem_req_ready = 1'b0;
        flush = 1'b1;
        pc_target = 32'h14;
        tick();
        flush = 1'b0;
        imem_req_ready = 1'b1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin
            n_err++;
            $display("FAIL flush_fetch: got valid=%b addr=%h, required 1/14", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back(32'h14);
        repeat (2) tick();
        // Flush and stall together while IF/ID holds 0x14 and a request fires
        stall = 1'b1;
        flush = 1'b1;
        pc_target = 32'h80;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== NOP || pc !== 32'h80) begin
            n_err++;
            $display("FAIL flush_stall: got ifid_v=%b instr=%h pc=%h, required 0/%h/80", if_id_valid, if_id_instruction, pc, NOP);
        end
        tick();
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin
            n_err++;
            $display("FAIL flush_resume: got valid=%b addr=%h, required 1/80", imem_req_valid, imem_req_addr);
        end
        exp_q.push_back(32'h80);
        repeat (2) tick();
        // Flush while an instruction sits in the skid buffer
        stall = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        pc_target = 32'h20;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || if_id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_hold: got valid=%b addr=%h ifid_v=%b, required 1/20/0", imem_req_valid, imem_req_addr, if_id_valid);
        end
        exp_q.push_back(32'h20);
        repeat (3) tick();
    endtask

    task automatic test_wrap_reset();
        imem_req_ready = 1'b0;
        flush = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pc_wrap: got pc=%h valid=%b, required 0/0", pc, imem_req_valid);
        end
        // Reset while waiting for the response of 0xFFFFFFFC
        reset = 1'b1;
        imem_resp_valid = 1'b0;
        mem_cnt = 0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instruction !== NOP) begin
            n_err++;
            $display("FAIL reset_mid_wait: got req=%b pc=%h ifid=%b/%h/%h, required 0/0/0/0/%h", imem_req_valid, pc, if_id_valid, if_id_pc, if_id_instruction, NOP);
        end
        tick();
        reset = 1'b0;
        exp_q.push_back(32'h0);
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0 || pc !== 32'h4) begin
            n_err++;
            $display("FAIL after_reset: got left=%0d pc=%h, required 0/4", exp_q.size(), pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        pc_target = 32'h0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        test_reset();
        test_basic();
        test_ready_low();
        test_stall_skid();
        test_flush_wait();
        test_flush_stall();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
